// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI read channel (AR+R) between fetch (port 0) and load (port 1), one burst at a time.
module axi_read_arbiter #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            rq_valid,
  output logic [1:0]            rq_ready,
  input  logic [ADDR_WIDTH-1:0] rq0_addr,
  input  logic [ADDR_WIDTH-1:0] rq1_addr,
  input  logic [7:0]            rq0_len,
  input  logic [7:0]            rq1_len,
  output logic [DATA_WIDTH-1:0] rs_rdata,
  output logic [1:0]            rs_rresp,
  output logic                  rs_rlast,
  output logic [1:0]            rs_rvalid,
  input  logic [1:0]            rs_rready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic                  win, in_data, last_hs;
  logic                  unused_rid;
  assign unused_rid = ^m_axi_rid;
  assign in_data = state_q == DATA;
  assign last_hs = in_data && m_axi_rvalid && m_axi_rready && m_axi_rlast;
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
  logic last_q, last_d, id_err_q, id_err_d, unused_id_err;
  assign unused_id_err = id_err_q;
  assign win = &rq_valid ? ~last_q : rq_valid[1];
  assign last_d = last_hs ? grant_q : last_q;
  assign id_err_d = id_err_q | (in_data && m_axi_rvalid && m_axi_rid[0] != grant_q);
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q   <= 1'b1;
      id_err_q <= 1'b0;
    end else begin
      last_q   <= last_d;
      id_err_q <= id_err_d;
    end
  end
`else
  assign win = rq_valid[1];
`endif
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    arid_d   = arid_q;
    if (state_q == IDLE && |rq_valid) begin
      state_d  = ADDR;
      grant_d  = win;
      araddr_d = win ? rq1_addr : rq0_addr;
      arlen_d  = win ? rq1_len : rq0_len;
      arid_d   = ID_WIDTH'(win);
    end
    if (state_q == ADDR && m_axi_arready) state_d = DATA;
    if (last_hs) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      araddr_q <= '0;
      arlen_q  <= '0;
      arid_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      arid_q   <= arid_d;
    end
  end
  assign m_axi_arvalid = state_q == ADDR;
  assign m_axi_arid    = arid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_arburst = 2'b01;
  assign rq_ready      = (m_axi_arvalid && m_axi_arready) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign m_axi_rready  = in_data && rs_rready[grant_q];
  assign rs_rvalid     = {in_data && m_axi_rvalid && grant_q, in_data && m_axi_rvalid && !grant_q};
  assign rs_rdata      = m_axi_rdata;
  assign rs_rresp      = m_axi_rresp;
  assign rs_rlast      = m_axi_rlast;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: randomized self-checking bench against a policy-level arbitration model.
module tb_axi_read_arbiter;
  logic        clk = 0, reset;
  logic [1:0]  rq_valid, rq_ready, rs_rvalid, rs_rready, rs_rresp, m_axi_arburst, m_axi_rresp;
  logic [63:0] rq0_addr, rq1_addr, rs_rdata, m_axi_araddr, m_axi_rdata;
  logic [7:0]  rq0_len, rq1_len, m_axi_arlen;
  logic        rs_rlast, m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [12:0] m_axi_arid, m_axi_rid;
  logic [2:0]  m_axi_arsize;
  int          errors = 0, checks = 0;
  logic        model_last;
  always #5 clk = ~clk;
  axi_read_arbiter dut (
    .clk(clk), .reset(reset), .rq_valid(rq_valid), .rq_ready(rq_ready),
    .rq0_addr(rq0_addr), .rq1_addr(rq1_addr), .rq0_len(rq0_len), .rq1_len(rq1_len),
    .rs_rdata(rs_rdata), .rs_rresp(rs_rresp), .rs_rlast(rs_rlast), .rs_rvalid(rs_rvalid),
    .rs_rready(rs_rready), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );
  function automatic logic model_win(input logic [1:0] req);
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
    return (req == 2'b11) ? ~model_last : req[1];
`else
    return req[1];
`endif
  endfunction
  task automatic idle_inputs();
    rq_valid = 0; rs_rready = 0; m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
    m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rid = 0;
  endtask
  // Runs one burst as requester + slave; returns observations only, the callers judge them.
  task automatic burst(input logic [1:0] req, input logic [63:0] a0, a1, input logic [7:0] l0, l1,
                       input logic ge, input int ar_dly, input bit tog, input bit hold,
                       output int lat, output logic [12:0] id, output logic [63:0] addr,
                       output logic [7:0] len, output logic [1:0] rdy, output bit stable,
                       output int beats, output bit route_ok, output bit idle_ok,
                       output time t_ar, output time t_last);
    int n, k, cyc;
    @(negedge clk);
    rq_valid = req; rq0_addr = a0; rq1_addr = a1; rq0_len = l0; rq1_len = l1;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; rs_rready = 0;
    #1;
    lat = 0;
    while (!m_axi_arvalid && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    t_ar = $time; id = m_axi_arid; addr = m_axi_araddr; len = m_axi_arlen; stable = m_axi_arvalid;
    for (int i = 0; i < ar_dly; i++) begin
      @(negedge clk); #1;
      if (!m_axi_arvalid || m_axi_arid !== id || m_axi_araddr !== addr || m_axi_arlen !== len || rq_ready !== 2'b00) stable = 0;
    end
    @(negedge clk);
    m_axi_arready = 1;
    #1;
    rdy = rq_ready;
    if (!m_axi_arvalid || m_axi_arid !== id || m_axi_araddr !== addr || m_axi_arlen !== len) stable = 0;
    @(negedge clk);
    m_axi_arready = 0;
    if (!hold) rq_valid = 0;
    n = int'(len) + 1; k = 0; cyc = 0; route_ok = 1; t_last = 0;
    while (k < n && cyc < 400) begin
      m_axi_rvalid = $urandom_range(0, 3) != 0;
      m_axi_rdata = {$urandom, $urandom};
      m_axi_rresp = 2'($urandom);
      m_axi_rid = 13'(ge);
      m_axi_rlast = k == n - 1;
      rs_rready = tog ? 2'($urandom) : 2'b11;
      #1;
      if (rs_rvalid !== (m_axi_rvalid ? (ge ? 2'b10 : 2'b01) : 2'b00) || m_axi_rready !== rs_rready[ge] ||
          rs_rdata !== m_axi_rdata || rs_rresp !== m_axi_rresp || rs_rlast !== m_axi_rlast) route_ok = 0;
      if (m_axi_rvalid && m_axi_rready) begin
        k++; t_last = $time;
      end
      @(negedge clk);
      cyc++;
    end
    beats = k;
    m_axi_rvalid = 1; m_axi_rlast = 1; rs_rready = 2'b11;
    #1;
    idle_ok = rs_rvalid === 2'b00 && m_axi_rready === 1'b0;
    m_axi_rvalid = 0; m_axi_rlast = 0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    reset = 1; rq_valid = 2'b11; m_axi_arready = 1; m_axi_rvalid = 1; rs_rready = 2'b11;
    rq0_addr = 64'h1234; rq1_addr = 64'h5678; rq0_len = 3; rq1_len = 4;
    @(negedge clk); @(negedge clk);
    checks++; if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", m_axi_arvalid); end
    checks++; if (m_axi_rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b want 0", m_axi_rready); end
    checks++; if (rq_ready !== 2'b00) begin errors++; $display("FAIL reset_rq_ready: got %b want 00", rq_ready); end
    checks++; if (rs_rvalid !== 2'b00) begin errors++; $display("FAIL reset_rs_rvalid: got %b want 00", rs_rvalid); end
    checks++; if (m_axi_araddr !== 64'h0) begin errors++; $display("FAIL reset_araddr: got %h want 0", m_axi_araddr); end
    checks++; if (m_axi_arlen !== 8'h0) begin errors++; $display("FAIL reset_arlen: got %h want 0", m_axi_arlen); end
    checks++; if (m_axi_arid !== 13'h0) begin errors++; $display("FAIL reset_arid: got %h want 0", m_axi_arid); end
    checks++; if (m_axi_arsize !== 3'd3) begin errors++; $display("FAIL arsize: got %0d want 3", m_axi_arsize); end
    checks++; if (m_axi_arburst !== 2'b01) begin errors++; $display("FAIL arburst: got %b want 01", m_axi_arburst); end
    reset = 0;
    idle_inputs();
    model_last = 1;
  endtask
  task automatic test_single_beat();
    int lat, beats; logic [12:0] id; logic [63:0] addr; logic [7:0] len; logic [1:0] rdy;
    bit st, ro, io; time ta, tl; logic g;
    g = model_win(2'b01);
    burst(2'b01, 64'h8000_0000, 64'h0, 8'd0, 8'd0, g, 0, 0, 0, lat, id, addr, len, rdy, st, beats, ro, io, ta, tl);
    model_last = g;
    checks++; if (lat !== 1) begin errors++; $display("FAIL single_latency: got %0d want 1", lat); end
    checks++; if (id !== 13'd0) begin errors++; $display("FAIL single_arid: got %0d want 0", id); end
    checks++; if (addr !== 64'h8000_0000) begin errors++; $display("FAIL single_araddr: got %h want 80000000", addr); end
    checks++; if (len !== 8'd0) begin errors++; $display("FAIL single_arlen: got %0d want 0", len); end
    checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL single_rq_ready: got %b want 01", rdy); end
    checks++; if (beats !== 1) begin errors++; $display("FAIL single_beats: got %0d want 1", beats); end
    checks++; if (!ro) begin errors++; $display("FAIL single_route: got 0 want 1"); end
    checks++; if (!io) begin errors++; $display("FAIL single_idle_after: got 0 want 1"); end
  endtask
  task automatic test_burst_backpressure();
    int lat, beats; logic [12:0] id; logic [63:0] addr; logic [7:0] len; logic [1:0] rdy;
    bit st, ro, io; time ta, tl; logic g;
    g = model_win(2'b10);
    burst(2'b10, 64'h0, 64'h1000, 8'd0, 8'd7, g, 3, 1, 0, lat, id, addr, len, rdy, st, beats, ro, io, ta, tl);
    model_last = g;
    checks++; if (id !== 13'd1) begin errors++; $display("FAIL bp_arid: got %0d want 1", id); end
    checks++; if (addr !== 64'h1000 || len !== 8'd7) begin errors++; $display("FAIL bp_fields: got %h/%0d want 1000/7", addr, len); end
    checks++; if (!st) begin errors++; $display("FAIL bp_ar_stable: got 0 want 1"); end
    checks++; if (rdy !== 2'b10) begin errors++; $display("FAIL bp_rq_ready: got %b want 10", rdy); end
    checks++; if (beats !== 8) begin errors++; $display("FAIL bp_beats: got %0d want 8", beats); end
    checks++; if (!ro) begin errors++; $display("FAIL bp_route: got 0 want 1"); end
    checks++; if (!io) begin errors++; $display("FAIL bp_idle_after: got 0 want 1"); end
  endtask
  task automatic test_tie();
    int lat, beats; logic [12:0] id; logic [63:0] addr; logic [7:0] len; logic [1:0] rdy;
    bit st, ro, io; time ta, tl; logic g;
    for (int r = 0; r < 3; r++) begin
      g = model_win(2'b11);
      burst(2'b11, 64'hA000 + 64'(r), 64'hB000 + 64'(r), 8'd1, 8'd2, g, r, 0, 0, lat, id, addr, len, rdy, st, beats, ro, io, ta, tl);
      model_last = g;
      checks++; if (id !== 13'(g)) begin errors++; $display("FAIL tie_grant_%0d: got %0d want %0d", r, id, g); end
      checks++; if (addr !== (g ? 64'hB000 + 64'(r) : 64'hA000 + 64'(r))) begin errors++; $display("FAIL tie_addr_%0d: got %h", r, addr); end
      checks++; if (beats !== (g ? 3 : 2) || !ro) begin errors++; $display("FAIL tie_beats_%0d: got %0d route %b", r, beats, ro); end
    end
  endtask
  task automatic test_reset_mid_burst();
    int k, lat, beats; logic [12:0] id; logic [63:0] addr; logic [7:0] len; logic [1:0] rdy;
    bit st, ro, io; time ta, tl;
    @(negedge clk);
    rq_valid = 2'b01; rq0_addr = 64'h2000; rq0_len = 8'd7; m_axi_arready = 1;
    @(negedge clk);
    rq_valid = 2'b00;
    @(negedge clk);
    m_axi_arready = 0;
    k = 0;
    for (int i = 0; i < 3; i++) begin
      m_axi_rvalid = 1; m_axi_rlast = 0; rs_rready = 2'b11; m_axi_rdata = 64'(i);
      #1;
      if (m_axi_rvalid && m_axi_rready) k++;
      @(negedge clk);
    end
    checks++; if (k !== 3) begin errors++; $display("FAIL rst_mid_pre_beats: got %0d want 3", k); end
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    checks++; if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_arvalid: got %b want 0", m_axi_arvalid); end
    checks++; if (m_axi_rready !== 1'b0) begin errors++; $display("FAIL rst_mid_rready: got %b want 0", m_axi_rready); end
    checks++; if (rs_rvalid !== 2'b00) begin errors++; $display("FAIL rst_mid_rs_rvalid: got %b want 00", rs_rvalid); end
    idle_inputs();
    model_last = 1;
    burst(2'b10, 64'h0, 64'h3000, 8'd0, 8'd2, model_win(2'b10), 1, 0, 0, lat, id, addr, len, rdy, st, beats, ro, io, ta, tl);
    model_last = 1;
    checks++; if (id !== 13'd1 || addr !== 64'h3000 || lat !== 1) begin errors++; $display("FAIL rst_mid_next_ar: got id %0d addr %h lat %0d want 1/3000/1", id, addr, lat); end
    checks++; if (beats !== 3 || !ro || !io) begin errors++; $display("FAIL rst_mid_next_data: got beats %0d route %b idle %b want 3/1/1", beats, ro, io); end
  endtask
  task automatic test_back_to_back();
    int lat, beats; logic [12:0] id; logic [63:0] addr; logic [7:0] len; logic [1:0] rdy;
    bit st, ro, io; time ta, tl, tl1;
    burst(2'b01, 64'h4000, 64'h0, 8'd2, 8'd0, 1'b0, 0, 0, 1, lat, id, addr, len, rdy, st, beats, ro, io, ta, tl1);
    model_last = 0;
    checks++; if (beats !== 3 || !ro || !io) begin errors++; $display("FAIL b2b_first: got beats %0d route %b idle %b want 3/1/1", beats, ro, io); end
    burst(2'b01, 64'h4000, 64'h0, 8'd2, 8'd0, 1'b0, 0, 0, 0, lat, id, addr, len, rdy, st, beats, ro, io, ta, tl);
    checks++; if ((ta - tl1) / 10 < 2) begin errors++; $display("FAIL b2b_gap: got %0d cycles want >=2", (ta - tl1) / 10); end
    checks++; if (id !== 13'd0 || addr !== 64'h4000 || beats !== 3 || !ro) begin errors++; $display("FAIL b2b_second: got id %0d addr %h beats %0d", id, addr, beats); end
  endtask
  task automatic test_random();
    int lat, beats, dly; logic [12:0] id; logic [63:0] addr, a0, a1; logic [7:0] len, l0, l1; logic [1:0] rdy, req;
    bit st, ro, io, tog; time ta, tl; logic g;
    for (int r = 0; r < 25; r++) begin
      req = 2'($urandom_range(1, 3));
      a0 = {$urandom, $urandom}; a1 = {$urandom, $urandom};
      l0 = 8'($urandom_range(0, 5)); l1 = 8'($urandom_range(0, 5));
      dly = $urandom_range(0, 3); tog = 1'($urandom);
      g = model_win(req);
      burst(req, a0, a1, l0, l1, g, dly, tog, 0, lat, id, addr, len, rdy, st, beats, ro, io, ta, tl);
      model_last = g;
      checks++; if (id !== 13'(g)) begin errors++; $display("FAIL rnd_grant_%0d: req %b got %0d want %0d", r, req, id, g); end
      checks++; if (addr !== (g ? a1 : a0) || len !== (g ? l1 : l0)) begin errors++; $display("FAIL rnd_fields_%0d: got %h/%0d", r, addr, len); end
      checks++; if (lat !== 1 || !st) begin errors++; $display("FAIL rnd_ar_%0d: got lat %0d stable %b want 1/1", r, lat, st); end
      checks++; if (rdy !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rnd_rq_ready_%0d: got %b", r, rdy); end
      checks++; if (beats !== int'(g ? l1 : l0) + 1 || !ro || !io) begin errors++; $display("FAIL rnd_data_%0d: got beats %0d route %b idle %b", r, beats, ro, io); end
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1;
    idle_inputs();
    rq0_addr = 0; rq1_addr = 0; rq0_len = 0; rq1_len = 0;
    test_reset();
    test_single_beat();
    test_burst_backpressure();
    test_tie();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
